// File: rtl/wb_uart_tx.sv
// Purpose: Wishbone B4 classic slave that queues byte writes and serialises them as 8N1 frames on txd_o.
// Latency: ack one cycle after stb; txd_o falls one cycle after the push edge when the shifter is idle.
// Backpressure: none on the bus; a write into a full FIFO is acked, dropped and flagged as overflow.
module wb_uart_tx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        txd_o,
    output logic        tx_idle_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Bus decode
    logic          valid;
    logic          acc;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          ovf_clr;
    logic          overflow_q;
    logic [31:0]   status;

    // FIFO storage
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] count_q;

    // Shifter
    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          bit_end;

    // Address/data bits outside the decoded register map
    logic          unused_ok;
    assign unused_ok = ^{wb_adr_i[31:3], wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};

    // An access takes effect only on the edge that raises ack, so one effect per transaction
    assign valid    = wb_cyc_i & wb_stb_i;
    assign acc      = valid & ~wb_ack_o;
    assign push_req = acc & wb_we_i & ~wb_adr_i[2] & wb_sel_i[0];
    assign full     = (count_q == LW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    // Fullness uses the pre-edge count: a same-edge pop does not rescue a push into a full FIFO
    assign push     = push_req & ~full;
    assign ovf_clr  = acc & wb_we_i & wb_adr_i[2] & wb_dat_i[3];

    // Status word built from pre-edge state
    always_comb begin
        status          = '0;
        status[0]       = full;
        status[1]       = empty;
        status[2]       = (state_q != S_IDLE);
        status[3]       = overflow_q;
        status[8 +: LW] = count_q;
    end

    // Bus response registers and sticky overflow flag
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wb_ack_o <= acc;
            if (acc && !wb_we_i && wb_adr_i[2]) begin
                wb_dat_o <= status;
            end else begin
                wb_dat_o <= '0;
            end
            if (push_req && full) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // FIFO storage write; contents need no reset since the pointers define validity
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= wb_dat_i[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as the depth is a power of two
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + LW'(1);
                2'b01:   count_q <= count_q - LW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Shifter state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign bit_end = (div_q == DW'(CLK_DIV - 1));

    // Next-state: txd is registered alongside the state so each bit holds exactly CLK_DIV cycles
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                div_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    state_d = S_START;
                    txd_d   = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    div_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    div_d = '0;
                    if (!empty) begin
                        // Back-to-back frames: next start bit follows the stop bit directly
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = S_START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    assign txd_o     = txd_q;
    assign tx_idle_o = empty & (state_q == S_IDLE);

endmodule

// File: tb/tb_wb_uart_tx.sv
// Purpose: directed self-checking bench for wb_uart_tx with CLK_DIV=4, FIFO_DEPTH=4.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: every wait on ack is bounded; a missing ack is reported as a failed check.
module tb_wb_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [31:0] dat_o;
    logic        ack;
    logic        txd;
    logic        tx_idle;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        txd_at_ack;
    logic        idle_at_ack;
    logic [31:0] rd;

    wb_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst_n),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat),
        .wb_sel_i  (sel),
        .wb_we_i   (we),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_dat_o  (dat_o),
        .wb_ack_o  (ack),
        .txd_o     (txd),
        .tx_idle_o (tx_idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One bus access starting at a falling edge; returns one idle cycle after the ack
    task automatic wb_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic w, input string tag, output logic [31:0] rdata);
        int lat = 0;
        adr = a; dat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack && lat < 4);
        check({tag, " ack latency"}, lat, 1);
        rdata       = dat_o;
        txd_at_ack  = txd;
        idle_at_ack = tx_idle;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        @(negedge clk);
        check({tag, " ack single"}, {31'd0, ack}, 0);
    endtask

    // Called on the first falling edge of a start bit; returns on the first falling edge after the stop bit
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic e;
        check({tag, " start edge"}, {31'd0, txd}, 0);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      e = 1'b0;
            else if (k == 9) e = 1'b1;
            else             e = b[k-1];
            check($sformatf("%s bit%0d", tag, k), {31'd0, txd}, {31'd0, e});
            if (k < 9) repeat (4) @(negedge clk);
        end
        @(negedge clk);
        check({tag, " busy in stop"}, {31'd0, tx_idle}, 0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        repeat (2) @(negedge clk);
        check("reset ack", {31'd0, ack}, 0);
        check("reset dat", dat_o, 0);
        check("reset txd", {31'd0, txd}, 1);
        check("reset idle", {31'd0, tx_idle}, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single frame 0xA5
        wb_xfer(32'h0, 32'h0000_00A5, 4'h1, 1'b1, "t1 wr", rd);
        check("t1 txd high at ack", {31'd0, txd_at_ack}, 1);
        check("t1 idle low at ack", {31'd0, idle_at_ack}, 0);
        check_frame(8'hA5, "t1");
        check("t1 idle after stop", {31'd0, tx_idle}, 1);
        check("t1 txd after stop", {31'd0, txd}, 1);

        // 2: three back-to-back bytes, contiguous frames
        fork
            begin
                wb_xfer(32'h0, 32'h41, 4'h1, 1'b1, "t2 wr0", rd);
                wb_xfer(32'h0, 32'h42, 4'h1, 1'b1, "t2 wr1", rd);
                wb_xfer(32'h0, 32'h43, 4'h1, 1'b1, "t2 wr2", rd);
                wb_xfer(32'h4, 32'h0, 4'hF, 1'b0, "t2 rd", rd);
                check("t2 status", rd, 32'h0000_0204);
            end
            begin
                repeat (2) @(negedge clk);
                check_frame(8'h41, "t2 f0");
                check_frame(8'h42, "t2 f1");
                check_frame(8'h43, "t2 f2");
                check("t2 idle", {31'd0, tx_idle}, 1);
            end
        join

        // 3 and 4: overflow a 4-entry FIFO, then clear overflow while still full
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    wb_xfer(32'h0, 32'h10 + i, 4'h1, 1'b1, "t3 wr", rd);
                end
                wb_xfer(32'h4, 32'h0, 4'hF, 1'b0, "t3 rd", rd);
                check("t3 status", rd, 32'h0000_040D);
                wb_xfer(32'h4, 32'h8, 4'hF, 1'b1, "t4 clr", rd);
                wb_xfer(32'h4, 32'h0, 4'hF, 1'b0, "t4 rd", rd);
                check("t4 status", rd, 32'h0000_0405);
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    check_frame(8'h10 + 8'(i), "t3 f");
                end
                check("t3 idle", {31'd0, tx_idle}, 1);
                check("t3 txd", {31'd0, txd}, 1);
            end
        join

        // 5: byte lane 0 not selected, no push
        wb_xfer(32'h0, 32'h55, 4'b1110, 1'b1, "t5 wr", rd);
        wb_xfer(32'h4, 32'h0, 4'hF, 1'b0, "t5 rd", rd);
        check("t5 status", rd, 32'h0000_0002);
        check("t5 txd", {31'd0, txd}, 1);
        check("t5 idle", {31'd0, tx_idle}, 1);
        wb_xfer(32'h0, 32'h0, 4'hF, 1'b0, "t5 rdtx", rd);
        check("t5 txdata read", rd, 32'h0);

        // 6: asynchronous reset during data bit 3 with an ack pending
        wb_xfer(32'h0, 32'h35, 4'h1, 1'b1, "t6 wr0", rd);
        wb_xfer(32'h0, 32'h77, 4'h1, 1'b1, "t6 wr1", rd);
        repeat (15) @(negedge clk);
        check("t6 data bit3", {31'd0, txd}, 0);
        adr = 32'h4; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #2;
        check("t6 ack before reset", {31'd0, ack}, 1);
        rst_n = 1'b0;
        #1;
        check("t6 ack in reset", {31'd0, ack}, 0);
        check("t6 txd in reset", {31'd0, txd}, 1);
        check("t6 dat in reset", dat_o, 0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wb_xfer(32'h4, 32'h0, 4'hF, 1'b0, "t6 rd", rd);
        check("t6 status", rd, 32'h0000_0002);
        check("t6 txd", {31'd0, txd}, 1);
        check("t6 idle", {31'd0, tx_idle}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
